// File: rtl/divider_fsm.sv
// divider_fsm: tick-driven load/divide/show controller with a W-step restoring divider (clk, reset, tick_next/up/down in; leds, phase, busy, div_zero out)
module divider_fsm #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         tick_next,
  input  logic         tick_up,
  input  logic         tick_down,
  output logic [W-1:0] leds,
  output logic [2:0]   phase,
  output logic         busy,
  output logic         div_zero
);
  localparam int SW = $clog2(W + 1);
  localparam logic [2:0] LOAD_NUM = 3'd0;
  localparam logic [2:0] LOAD_DEN = 3'd1;
  localparam logic [2:0] DIVIDE   = 3'd2;
  localparam logic [2:0] SHOW_QUO = 3'd3;
  localparam logic [2:0] SHOW_REM = 3'd4;
  logic [2:0]    state;
  logic [W-1:0]  num, den, quo, rem, num_adj, den_adj;
  logic [SW-1:0] step;
  logic [W:0]    trial;
  logic          fit;
  always_comb begin
    trial   = {rem, quo[W-1]};
    fit     = trial >= {1'b0, den};
    num_adj = (tick_up && !tick_down) ? num + 1'b1 : (tick_down && !tick_up) ? num - 1'b1 : num;
    den_adj = (tick_up && !tick_down) ? den + 1'b1 : (tick_down && !tick_up) ? den - 1'b1 : den;
    leds    = state == LOAD_NUM ? num : state == LOAD_DEN ? den : state == SHOW_QUO ? quo :
              state == SHOW_REM ? rem : '0;
    phase   = state;
    busy    = state == DIVIDE;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= LOAD_NUM;
      num      <= '0;
      den      <= '0;
      quo      <= '0;
      rem      <= '0;
      step     <= '0;
      div_zero <= 1'b0;
    end else begin
      case (state)
        LOAD_NUM: begin
          num <= num_adj;
          if (tick_next) state <= LOAD_DEN;
        end
        LOAD_DEN: begin
          den <= den_adj;
          if (tick_next) begin
            state    <= DIVIDE;
            quo      <= num;
            rem      <= '0;
            step     <= '0;
            div_zero <= den_adj == '0;
          end
        end
        DIVIDE: begin
          if (div_zero) begin
            quo   <= '1;
            rem   <= num;
            state <= SHOW_QUO;
          end else begin
            // true remainder is below den, so the low W bits of trial - den are exact
            rem  <= fit ? trial[W-1:0] - den : trial[W-1:0];
            quo  <= {quo[W-2:0], fit};
            step <= step + 1'b1;
            if (step == SW'(W - 1)) state <= SHOW_QUO;
          end
        end
        SHOW_QUO: if (tick_next) state <= SHOW_REM;
        SHOW_REM: begin
          if (tick_next) begin
            state    <= LOAD_NUM;
            div_zero <= 1'b0;
          end
        end
        default: state <= LOAD_NUM;
      endcase
    end
  end
endmodule

// File: tb/tb_divider_fsm.sv
// tb_divider_fsm: randomized self-checking bench for divider_fsm at W=4 and W=8
module tb_divider_fsm;
  logic       clk = 0, reset = 1;
  logic       n4 = 0, u4 = 0, d4 = 0, n8 = 0, u8 = 0, d8 = 0;
  logic [3:0] l4;
  logic [7:0] l8;
  logic [2:0] p4, p8;
  logic       b4, b8, z4, z8;
  int         n_cmp = 0, n_bad = 0, mnum = 0, mden = 0;
  divider_fsm #(.W(4)) dut4 (.clk(clk), .reset(reset), .tick_next(n4), .tick_up(u4), .tick_down(d4),
                             .leds(l4), .phase(p4), .busy(b4), .div_zero(z4));
  divider_fsm #(.W(8)) dut8 (.clk(clk), .reset(reset), .tick_next(n8), .tick_up(u8), .tick_down(d8),
                             .leds(l8), .phase(p8), .busy(b8), .div_zero(z8));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic pulse(input logic nx, input logic up, input logic dn, input bit big);
    @(negedge clk);
    if (big) {n8, u8, d8} = {nx, up, dn};
    else {n4, u4, d4} = {nx, up, dn};
    @(negedge clk);
    {n4, u4, d4, n8, u8, d8} = '0;
  endtask
  task automatic do_reset();
    @(negedge clk);
    reset = 1;
    @(negedge clk);
    reset = 0;
    mnum = 0;
    mden = 0;
  endtask
  task automatic adjust(input int cur, input int tgt);
    if ($urandom_range(1) == 1) repeat ((tgt - cur) & 15) pulse(0, 1, 0, 0);
    else repeat ((cur - tgt) & 15) pulse(0, 0, 1, 0);
  endtask
  // busy-cycle count; junk ticks thrown at the DUT while it divides must be dropped
  task automatic busy_len(input bit big, output int lat);
    lat = 0;
    while ((big ? b8 : b4) && lat < 40) begin
      lat++;
      if (!big) {n4, u4, d4} = 3'($urandom);
      @(negedge clk);
    end
    {n4, u4, d4} = '0;
  endtask
  task automatic run4(input int n, input int d);
    int lat, eq, er;
    eq = d == 0 ? 15 : n / d;
    er = d == 0 ? n : n % d;
    adjust(mnum, n);
    mnum = n;
    chk("num_load", int'(l4), n);
    pulse(1, 0, 0, 0);
    chk("phase_den", int'(p4), 1);
    chk("den_keep", int'(l4), mden);
    adjust(mden, d);
    mden = d;
    chk("den_load", int'(l4), d);
    pulse(1, 0, 0, 0);
    busy_len(0, lat);
    chk("latency", lat, d == 0 ? 1 : 4);
    chk("phase_quo", int'(p4), 3);
    chk("quo", int'(l4), eq);
    chk("dz", int'(z4), int'(d == 0));
    pulse(1, 0, 0, 0);
    chk("phase_rem", int'(p4), 4);
    chk("rem", int'(l4), er);
    pulse(1, 0, 0, 0);
    chk("phase_back", int'(p4), 0);
    chk("dz_clear", int'(z4), 0);
    chk("num_kept", int'(l4), n);
  endtask
  task automatic run8(input int n, input int d);
    int lat;
    do_reset();
    if (n > 128) repeat (256 - n) pulse(0, 0, 1, 1);
    else repeat (n) pulse(0, 1, 0, 1);
    chk("w8_num", int'(l8), n);
    pulse(1, 0, 0, 1);
    repeat (d) pulse(0, 1, 0, 1);
    pulse(1, 0, 0, 1);
    busy_len(1, lat);
    chk("w8_latency", lat, 8);
    chk("w8_quo", int'(l8), n / d);
    pulse(1, 0, 0, 1);
    chk("w8_rem", int'(l8), n % d);
  endtask
  initial begin
    int lat;
    int pairs[$];
    repeat (2) @(negedge clk);
    reset = 0;
    chk("rst_leds", int'(l4), 0);
    chk("rst_phase", int'(p4), 0);
    chk("rst_busy", int'(b4), 0);
    chk("rst_dz", int'(z4), 0);
    chk("rst_phase8", int'(p8), 0);
    pulse(0, 0, 1, 0);
    chk("wrap_down", int'(l4), 15);
    pulse(0, 1, 0, 0);
    chk("wrap_up", int'(l4), 0);
    pulse(0, 1, 1, 0);
    chk("both_ticks", int'(l4), 0);
    run4(13, 4);
    run4(9, 0);
    // reset in the second divide cycle wipes everything, even with a tick alongside
    run4(7, 2);
    pulse(1, 0, 0, 0);
    adjust(7, 7);
    pulse(1, 0, 0, 0);
    @(negedge clk);
    chk("mid_busy", int'(b4), 1);
    reset = 1;
    u4 = 1;
    @(negedge clk);
    reset = 0;
    u4 = 0;
    mnum = 0;
    mden = 0;
    chk("mid_phase", int'(p4), 0);
    chk("mid_leds", int'(l4), 0);
    chk("mid_busy0", int'(b4), 0);
    pulse(1, 0, 0, 0);
    chk("mid_den", int'(l4), 0);
    pulse(1, 0, 0, 0);
    busy_len(0, lat);
    chk("mid_dz_lat", lat, 1);
    chk("mid_quo", int'(l4), 15);
    chk("mid_rem_num", int'(z4), 1);
    pulse(1, 0, 0, 0);
    chk("mid_rem", int'(l4), 0);
    pulse(1, 0, 0, 0);
    for (int i = 0; i < 256; i++) pairs.push_back(i);
    pairs.shuffle();
    foreach (pairs[i]) run4(pairs[i] >> 4, pairs[i] & 15);
    run8(200, 7);
    run8(5, 9);
    run8(255, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
